// File: rtl/midi_cmd_master_pkg.sv
// Shared MIDI constants, synth command encodings and parser state type for midi_cmd_master.
// Data-byte handling after a complete message depends on MIDI_RUNNING_STATUS_EN, which is used in the top-level module.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;

    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

    localparam logic [15:0] CMD_STOP_ALL    = 16'h7F00;
    localparam logic [15:0] CMD_WAVE_TOGGLE = 16'h8000;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_SKIP,
        PS_D1,
        PS_D2
    } parse_state_t;

    // Bit 7 of the command is unused padding so the velocity sits in the low byte.
    function automatic logic [15:0] build_note_cmd(input logic on, input logic [6:0] note,
                                                   input logic [6:0] vel);
        return {on, note, 1'b0, vel};
    endfunction

endpackage

// File: rtl/midi_cmd_master_if.sv
// Byte-stream input handshake plus Avalon-MM write-master bus of midi_cmd_master.
interface midi_cmd_master_if;

    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic [3:0]  avm_m0_address;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic        avm_m0_waitrequest;

    modport master (
        input  i_byte, i_byte_valid, avm_m0_waitrequest,
        output o_byte_ready, avm_m0_address, avm_m0_write, avm_m0_writedata
    );

    modport slave (
        output i_byte, i_byte_valid, avm_m0_waitrequest,
        input  o_byte_ready, avm_m0_address, avm_m0_write, avm_m0_writedata
    );

endinterface

// File: rtl/midi_cmd_master_fifo.sv
// midi_cmd_fifo: synchronous 16-bit command FIFO with extra-MSB wrap pointers.
module midi_cmd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic [15:0] head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [15:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/midi_cmd_master.sv
// midi_cmd_master: MIDI byte parser feeding a command FIFO drained by an Avalon-MM write master.
// Define MIDI_RUNNING_STATUS_EN to keep the status latched after each complete message.
module midi_cmd_master
    import midi_pkg::*;
#(
    parameter int CHANNEL    = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int WR_ADDR    = 0
) (
    input  logic              clk,
    input  logic              reset,
    midi_cmd_master_if.master bus,
    output logic              o_fifo_full,
    output logic [7:0]        o_dropped_count
);

`ifdef MIDI_RUNNING_STATUS_EN
    localparam parse_state_t MSG_DONE = PS_D1;
`else
    localparam parse_state_t MSG_DONE = PS_IDLE;
`endif

    parse_state_t state;
    logic [3:0]   status_kind;
    logic [6:0]   d1;

    logic         byte_accept;
    logic [3:0]   hi_nib;
    logic         is_realtime;
    logic         accept_status;
    logic         note_on;
    logic         push;
    logic         drop;
    logic [15:0]  push_cmd;
    logic         fifo_empty;
    logic         fifo_pop;
    logic [15:0]  fifo_head;

    assign hi_nib        = bus.i_byte[7:4];
    assign byte_accept   = bus.i_byte_valid && bus.o_byte_ready;
    assign is_realtime   = (bus.i_byte[7:3] == 5'b11111);
    assign accept_status = (bus.i_byte[3:0] == 4'(CHANNEL)) &&
                           (hi_nib == ST_NOTE_OFF || hi_nib == ST_NOTE_ON ||
                            hi_nib == ST_CC || hi_nib == ST_PROG);
    assign note_on       = (status_kind == ST_NOTE_ON) && (bus.i_byte[6:0] != 7'd0);

    // The command is decoded from the incoming byte so it lands in the FIFO on its accept edge.
    always_comb begin
        push     = 1'b0;
        drop     = 1'b0;
        push_cmd = '0;
        if (byte_accept && !bus.i_byte[7]) begin
            if (state == PS_D1 && status_kind == ST_PROG) begin
                push     = 1'b1;
                push_cmd = CMD_WAVE_TOGGLE;
            end else if (state == PS_D2) begin
                case (status_kind)
                    ST_NOTE_ON, ST_NOTE_OFF: begin
                        if ((note_on && d1 == 7'd0) || (!note_on && d1 == 7'd127)) begin
                            drop = 1'b1;
                        end else begin
                            push     = 1'b1;
                            push_cmd = build_note_cmd(note_on, d1, bus.i_byte[6:0]);
                        end
                    end
                    ST_CC: begin
                        if (d1 == CC_ALL_SOUND_OFF || d1 == CC_ALL_NOTES_OFF) begin
                            push     = 1'b1;
                            push_cmd = CMD_STOP_ALL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= PS_IDLE;
            status_kind     <= '0;
            d1              <= '0;
            o_dropped_count <= '0;
        end else begin
            if (drop && o_dropped_count != 8'hFF) begin
                o_dropped_count <= o_dropped_count + 8'd1;
            end
            if (byte_accept) begin
                if (bus.i_byte[7]) begin
                    if (is_realtime) begin
                        state <= state;
                    end else if (accept_status) begin
                        status_kind <= hi_nib;
                        state       <= PS_D1;
                    end else begin
                        status_kind <= '0;
                        state       <= PS_SKIP;
                    end
                end else begin
                    case (state)
                        PS_D1: begin
                            if (status_kind == ST_PROG) begin
                                state <= MSG_DONE;
                            end else begin
                                d1    <= bus.i_byte[6:0];
                                state <= PS_D2;
                            end
                        end
                        PS_D2:   state <= MSG_DONE;
                        default: state <= state;
                    endcase
                end
            end
        end
    end

    midi_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_cmd),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (o_fifo_full),
        .empty    (fifo_empty)
    );

    assign fifo_pop             = bus.avm_m0_write && !bus.avm_m0_waitrequest;
    assign bus.o_byte_ready     = !o_fifo_full;
    assign bus.avm_m0_address   = 4'(WR_ADDR);
    assign bus.avm_m0_write     = !fifo_empty;
    assign bus.avm_m0_writedata = {16'h0, fifo_empty ? 16'h0 : fifo_head};

endmodule

// File: doc/midi_cmd_master.md
# midi_cmd_master

MIDI byte-stream parser and Avalon-MM write master that drives the synthesizer's command slave (`avs_s0_*`). It accepts raw MIDI bytes from the UART/HPS byte path and translates channel messages into 16-bit synth command words:

- bit 15: 1 = note on, 0 = note off
- bits 14:8: note
- bits 7:0: velocity

Commands are buffered in a small FIFO and issued as single Avalon writes, honouring `waitrequest`.

## Interface
Parameters:
- `CHANNEL`, 0: MIDI channel (0-15) accepted; other channels are discarded.
- `FIFO_DEPTH`, 8: command FIFO entries; must be a power of 2, at least 2.
- `WR_ADDR`, 0: constant driven on `avm_m0_address`.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `i_byte` in 8: MIDI byte.
- `i_byte_valid` in 1: `i_byte` is valid.
- `o_byte_ready` out 1: byte is accepted on `i_byte_valid && o_byte_ready`.
- `avm_m0_address` out 4: always `WR_ADDR`.
- `avm_m0_write` out 1: write request.
- `avm_m0_writedata` out 32: `{16'h0, cmd[15:0]}`.
- `avm_m0_waitrequest` in 1: slave stall.
- `o_fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `o_dropped_count` out 8: saturating count of dropped reserved-note events.

## Operation
- **Byte classes:**
  - Status byte: bit7 = 1.
  - Real-time bytes (`F8`-`FF`) are accepted and ignored, with no state change.
  - `F0`-`F7` clear the running status and enter `SKIP`.
- **Parser states:**
  - `IDLE`: no valid status. Data bytes are ignored.
  - `SKIP`: discard data bytes until the next status byte.
  - `D1`: wait for the first data byte.
  - `D2`: wait for the second data byte.
- **Status byte in any state:**
  - `8n`/`9n`/`Bn` with n == `CHANNEL`: latch status, go to `D1`.
  - `Cn` with n == `CHANNEL`: latch status, go to `D1`.
  - Any other status byte: go to `SKIP`.
- **`D1`:**
  - For `Cn`: emit `WAVE_TOGGLE` = `16'h8000`, then go to `D1` (running status).
  - Otherwise: latch d1, go to `D2`.
- **`D2`:** latch d2, emit the command below, go to `D1` (running status).
- **Command mapping:**
  - `9n` with d2 != 0: `{1'b1, d1, 1'b0, d2}`.
  - `8n`, or `9n` with d2 == 0: `{1'b0, d1, 1'b0, d2}`.
  - `Bn` with d1 == 120 or d1 == 123: `STOP_ALL` = `16'h7F00`. Other controller numbers emit nothing.
- **Reserved notes:**
  - Note 0 on and note 127 off collide with the synth's wave-toggle and stop-all encodings.
  - Note-on with d1 == 0 and note-off with d1 == 127 are dropped, not emitted.
  - Each drop increments `o_dropped_count`, which saturates at 255.
- **FIFO behaviour:**
  - An emitted command is written into the FIFO on the same edge its final byte is accepted.
  - `o_byte_ready = !o_fifo_full`. Bytes are stalled, never lost.
- **Avalon master behaviour:**
  - `avm_m0_write = !fifo_empty`; `avm_m0_writedata` is the FIFO head.
  - The head is popped on an edge where `avm_m0_write && !avm_m0_waitrequest`.
  - While `waitrequest` is high, `write` and `writedata` are held stable.

## Timing
- **Reset values:**
  - `o_byte_ready` = 1.
  - `avm_m0_write` = 0.
  - `avm_m0_writedata` = 0.
  - `o_fifo_full` = 0.
  - `o_dropped_count` = 0.
  - Parser in `IDLE`, FIFO empty.
- **Reset mid-operation:** reset asserted during an outstanding write deasserts `avm_m0_write` in the next cycle. Pending FIFO entries and partial messages are discarded.
- **Latency:**
  - The final data byte is accepted at edge N.
  - `avm_m0_write` is high in the cycle after N when the FIFO was empty.
  - Minimum issue interval is 1 write per cycle.
- **Simultaneous push and pop:** with the FIFO non-full, both occur and occupancy is unchanged. A pop on a full FIFO raises `o_byte_ready` after that edge.
- **Wrap-around:** FIFO pointers are `log2(FIFO_DEPTH)+1` bits. Full is detected as MSBs differing with equal LSBs.
- **Throughput:** a 3-byte message needs at least 3 cycles; `D1`/`D2` never stall internally.

## Configuration
- **`MIDI_RUNNING_STATUS_EN` defined:**
  - After a complete message the parser returns to `D1`.
  - Subsequent data bytes reuse the latched status.
- **`MIDI_RUNNING_STATUS_EN` undefined:**
  - After a complete message the parser returns to `IDLE`.
  - Data bytes without a fresh status byte are ignored.

## Structure
- **Package `midi_pkg`:**
  - Status nibble constants `ST_NOTE_OFF`=8, `ST_NOTE_ON`=9, `ST_CC`=B, `ST_PROG`=C.
  - `CC_ALL_SOUND_OFF`=120, `CC_ALL_NOTES_OFF`=123.
  - `CMD_STOP_ALL`, `CMD_WAVE_TOGGLE`.
  - Parser state enum.
- **Sub-module `midi_cmd_fifo`:** synchronous 16-bit FIFO with push, pop, full and empty, and registered storage. It is instantiated once.

## Test plan
- `90 45 40`, waitrequest 0 → a single write of `32'h0000_C540`, with `avm_m0_write` high for exactly 1 cycle.
- `90 3C 20 3C 00` (running status) → writes `32'h0000_BC20`, then `32'h0000_3C00`. With the macro undefined: only the first write.
- `C0 05`, then `B0 7B 00` → writes `32'h0000_8000`, then `32'h0000_7F00`.
- `91 45 40` with `CHANNEL`=0 → no write. `90 00 40` → no write and `o_dropped_count`=1. `F8` interleaved mid-message → no effect.
- `avm_m0_waitrequest` held high while 9 note-ons are fed (`FIFO_DEPTH`=8):
  - `o_fifo_full`=1 and `o_byte_ready`=0 after the 8th command.
  - Release waitrequest → all 9 writes appear in order with stable data during stalls.
- Reset asserted while `avm_m0_write`=1 → `avm_m0_write`=0 next cycle, FIFO empty, parser `IDLE`.
